// File: rtl/disp_ch_sched_pkg.sv
// Shared encodings for the display channel scheduler: modes, FSM states
// and channel count.
package disp_ch_sched_pkg;

  localparam int unsigned NUM_CH = 8;

  typedef enum logic [1:0] {
    MODE_MAN  = 2'b00,
    MODE_AUTO = 2'b01,
    MODE_REQ  = 2'b10,
    MODE_MAN2 = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_NEXT = 2'd2
  } state_e;

endpackage

// File: rtl/disp_ch_sched_rr_pick8.sv
// Circular first-one search over 8 requesters, starting just after ptr.
// Purely combinational; ptr itself is searched last.
module rr_pick8
  import disp_ch_sched_pkg::*;
(
  input  logic [7:0] req,
  input  logic [2:0] ptr,
  output logic       valid,
  output logic [2:0] idx
);

  logic [2:0] w_pos;

  always_comb begin
    valid = 1'b0;
    idx   = ptr;
    w_pos = ptr;
    for (int unsigned k = 1; k <= NUM_CH; k++) begin
      w_pos = ptr + 3'(k);
      if (!valid && req[w_pos]) begin
        valid = 1'b1;
        idx   = w_pos;
      end
    end
  end

endmodule

// File: rtl/disp_ch_sched.sv
// Display channel scheduler: manual select, timed auto-scan, or
// request-driven round-robin onto an 8-channel display mux.
module disp_ch_sched
  import disp_ch_sched_pkg::*;
#(
  parameter logic [31:0] DWELL_CYC = 32'd50_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] mode,
  input  logic [2:0] sw_sel,
  input  logic [7:0] req,
  input  logic       cpu_wr,
  output logic [2:0] Test,
  output logic       EN,
  output logic [7:0] grant,
  output logic       ch_chg
);

  state_e      r_state, w_state_nxt;
  logic [31:0] r_cnt, w_cnt_nxt, w_cnt_inc;
  logic [2:0]  r_ptr, w_ptr_nxt;
  logic [1:0]  r_mode;
  logic [2:0]  w_test_nxt;
  logic [7:0]  w_grant_nxt;
  logic        w_auto, w_reqm, w_manual;
  logic        w_pick_vld;
  logic [2:0]  w_pick_idx;

  assign w_auto   = (mode == MODE_AUTO);
  assign w_reqm   = (mode == MODE_REQ);
  assign w_manual = !(w_auto || w_reqm);

  rr_pick8 u_pick (
    .req   (req),
    .ptr   (r_ptr),
    .valid (w_pick_vld),
    .idx   (w_pick_idx)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_ptr_nxt   = r_ptr;
    w_test_nxt  = Test;
    w_grant_nxt = grant;
    w_cnt_inc   = r_cnt + 32'd1;

    if (mode != r_mode) begin
      w_state_nxt = ST_IDLE;
      w_cnt_nxt   = '0;
      w_grant_nxt = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_auto || (w_reqm && (req != 8'd0))) w_state_nxt = ST_NEXT;
        end
        ST_NEXT: begin
          w_cnt_nxt = '0;
          if (w_auto) begin
            w_test_nxt  = Test + 3'd1;
            w_grant_nxt = 8'b1 << (Test + 3'd1);
            w_ptr_nxt   = Test + 3'd1;
            w_state_nxt = ST_HOLD;
          end else if (w_reqm && w_pick_vld) begin
            w_test_nxt  = w_pick_idx;
            w_grant_nxt = 8'b1 << w_pick_idx;
            w_ptr_nxt   = w_pick_idx;
            w_state_nxt = ST_HOLD;
          end else begin
            w_grant_nxt = '0;
            w_state_nxt = ST_IDLE;
          end
        end
        ST_HOLD: begin
          // Terminal compare on the incremented count so that the NEXT cycle
          // is part of the dwell: each channel is shown DWELL_CYC cycles.
          w_cnt_nxt = w_cnt_inc;
          if ((w_cnt_inc == DWELL_CYC - 32'd1) || (w_reqm && !req[Test]))
            w_state_nxt = ST_NEXT;
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end

    if (w_manual) begin
      w_test_nxt  = sw_sel;
      w_grant_nxt = 8'b1 << sw_sel;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_ptr   <= 3'd7;
      r_mode  <= MODE_MAN;
      Test    <= '0;
      EN      <= 1'b0;
      grant   <= '0;
      ch_chg  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ptr   <= w_ptr_nxt;
      r_mode  <= mode;
      Test    <= w_test_nxt;
      EN      <= cpu_wr;
      grant   <= w_grant_nxt;
      ch_chg  <= (w_test_nxt != Test);
    end
  end

endmodule

// File: tb/tb_disp_ch_sched.sv
// Bench for disp_ch_sched: behavioural model compared every cycle, plus
// directed scenarios with hand-computed expectations.
module tb_disp_ch_sched;

  localparam int DW = 4;

  logic       clk, rst;
  logic [1:0] mode;
  logic [2:0] sw_sel;
  logic [7:0] req;
  logic       cpu_wr;
  logic [2:0] Test;
  logic       EN;
  logic [7:0] grant;
  logic       ch_chg;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  disp_ch_sched #(.DWELL_CYC(32'd4)) dut (
    .clk    (clk),
    .rst    (rst),
    .mode   (mode),
    .sw_sel (sw_sel),
    .req    (req),
    .cpu_wr (cpu_wr),
    .Test   (Test),
    .EN     (EN),
    .grant  (grant),
    .ch_chg (ch_chg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model. phase: 0 = nothing shown, 1 = choosing a channel
  // this cycle, 2 = showing; held = cycles shown since the choice.
  logic [2:0] m_t   = 3'd0;
  logic [7:0] m_g   = 8'd0;
  logic       m_en  = 1'b0;
  logic       m_chg = 1'b0;
  int         m_last = 7;
  logic [1:0] m_prev = 2'd0;
  int         m_phase = 0;
  int         m_held  = 0;
  int         nt;
  bit         man, found;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_t = 0; m_g = 0; m_en = 0; m_chg = 0;
      m_last = 7; m_prev = 0; m_phase = 0; m_held = 0;
    end else begin
      man  = !(mode == 2'd1 || mode == 2'd2);
      nt   = m_t;
      m_en = cpu_wr;
      if (mode != m_prev) begin
        m_phase = 0;
        m_g     = 0;
      end else if (!man) begin
        if (m_phase == 0) begin
          if (mode == 2'd1 || req != 0) m_phase = 1;
        end else if (m_phase == 1) begin
          found = 0;
          if (mode == 2'd1) begin
            nt = (m_t + 1) % 8;
            found = 1;
          end else begin
            for (int k = 1; k <= 8; k++)
              if (!found && req[(m_last + k) % 8]) begin
                nt = (m_last + k) % 8;
                found = 1;
              end
          end
          if (found) begin
            m_g = 8'(1 << nt); m_last = nt; m_phase = 2; m_held = 0;
          end else begin
            m_g = 0; m_phase = 0;
          end
        end else begin
          m_held++;
          if (m_held == DW - 1 || (mode == 2'd2 && !req[m_t])) m_phase = 1;
        end
      end
      if (man) begin
        nt  = sw_sel;
        m_g = 8'(1 << sw_sel);
      end
      m_chg  = (nt != m_t);
      m_t    = 3'(nt);
      m_prev = mode;
    end
  end

  // Per-cycle compare plus a log of channel changes for directed checks.
  int q_t[$];
  int q_c[$];
  always @(negedge clk) begin
    chk("cycle {Test,grant,EN,ch_chg}", {19'd0, Test, grant, EN, ch_chg},
        {19'd0, m_t, m_g, m_en, m_chg});
    if (rst && ch_chg) begin
      q_t.push_back(Test);
      q_c.push_back(cyc);
    end
  end

  task automatic step();
    @(posedge clk); #2;
  endtask

  task automatic do_reset(input logic [1:0] md, input logic [7:0] rq);
    rst = 1'b0; mode = md; req = rq; cpu_wr = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    q_t.delete(); q_c.delete();
  endtask

  task automatic wait_test(input logic [2:0] v, input string name);
    bit ok = 0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (Test == v) ok = 1;
    end
    if (!ok) chk({name, " wait timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    rst = 1'b0; mode = 2'd0; sw_sel = 3'd0; req = 8'd0; cpu_wr = 1'b0;
    @(negedge clk);
    chk("reset outputs", {Test, grant, EN, ch_chg}, 13'd0);

    // Auto-scan sequence and dwell spacing
    do_reset(2'd1, 8'd0);
    repeat (45) step();
    chk("auto change count", q_t.size() >= 8, 1);
    if (q_t.size() >= 8)
      for (int i = 0; i < 8; i++) begin
        chk("auto seq", q_t[i], (i + 1) % 8);
        if (i > 0) chk("auto dwell", q_c[i] - q_c[i-1], DW);
      end

    // Request round-robin order
    do_reset(2'd2, 8'b1010_0100);
    repeat (25) step();
    chk("rr change count", q_t.size() >= 4, 1);
    if (q_t.size() >= 4) begin
      chk("rr g0", q_t[0], 2); chk("rr g1", q_t[1], 5);
      chk("rr g2", q_t[2], 7); chk("rr g3", q_t[3], 2);
    end

    // Early release from channel 5 to channel 0
    do_reset(2'd2, 8'b0010_0000);
    wait_test(3'd5, "early");
    step();
    req = 8'b0000_0001;
    @(negedge clk); chk("early hold", Test, 5);
    @(negedge clk); chk("early next", Test, 5);
    @(negedge clk);
    chk("early Test", Test, 0);
    chk("early grant", grant, 8'h01);
    chk("early chg", ch_chg, 1);

    // Manual select 3 -> 6
    mode = 2'd0; sw_sel = 3'd3;
    repeat (4) step();
    sw_sel = 3'd6;
    @(negedge clk); chk("man before", Test, 3);
    @(negedge clk);
    chk("man Test", Test, 6);
    chk("man grant", grant, 8'h40);
    chk("man chg", ch_chg, 1);
    @(negedge clk); chk("man chg once", ch_chg, 0);

    // Single cpu_wr pulse
    step(); cpu_wr = 1'b1;
    step(); cpu_wr = 1'b0;
    @(negedge clk); chk("EN pulse", EN, 1);
    @(negedge clk); chk("EN single", EN, 0);

    // Async reset mid-HOLD on channel 4, resume from channel 1
    do_reset(2'd1, 8'd0);
    wait_test(3'd4, "rst");
    @(posedge clk); #3 rst = 1'b0;
    #1;
    chk("async rst Test", Test, 0);
    chk("async rst grant", grant, 0);
    @(posedge clk); #2 rst = 1'b1;
    q_t.delete(); q_c.delete();
    repeat (10) step();
    chk("post-rst first grant present", q_t.size() >= 1, 1);
    if (q_t.size() >= 1) chk("post-rst first grant", q_t[0], 1);

    // Randomised traffic against the model
    for (int i = 0; i < 2000; i++) begin
      step();
      if ($urandom_range(0, 39) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 5) == 0)
        case ($urandom_range(0, 3))
          0: req = 8'd0;
          1: req = 8'(1 << $urandom_range(0, 7));
          default: req = 8'($urandom);
        endcase
      if ($urandom_range(0, 4) == 0) sw_sel = 3'($urandom_range(0, 7));
      cpu_wr = ($urandom_range(0, 3) == 0);
    end
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/disp_ch_sched.md
DISP_CH_SCHED -- requirements
Module: disp_ch_sched

Interface
REQ-001 Parameter DWELL_CYC, default 32'd50_000_000, SHALL set the cycles each channel is held in auto/request modes (legal range 2..2^32-1).
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 mode  input  2  SHALL select the mode: 00 manual, 01 auto-scan, 10 request round-robin, 11 treated as 00.
REQ-005 sw_sel  input  3  SHALL be the manual channel number.
REQ-006 req  input  8  SHALL carry the per-channel display requests, bit i for channel i.
REQ-007 cpu_wr  input  1  SHALL be the CPU display-write strobe for channel 0 data.
REQ-008 Test  output  3  SHALL be the channel select driven to the 8-channel display mux.
REQ-009 EN  output  1  SHALL be the one-cycle latch enable for channel 0 data.
REQ-010 grant  output  8  SHALL be the one-hot current grant, or 0 when idle.
REQ-011 ch_chg  output  1  SHALL pulse for exactly one cycle in every cycle where Test changes value.

Function
REQ-012 EN SHALL equal cpu_wr delayed by one clock, independent of mode and state.
REQ-013 Manual mode: Test SHALL be sw_sel registered (1-cycle latency); grant SHALL be 1<<Test; no dwell counter activity.
REQ-014 FSM states SHALL be IDLE, HOLD, NEXT.
REQ-015 IDLE -> NEXT when auto-scan is selected, or when request mode is selected with req != 0; otherwise remain in IDLE.
REQ-016 NEXT: lasts one cycle; loads the next channel into Test and grant; clears the dwell counter; goes to HOLD.
REQ-017 HOLD: the dwell counter increments each cycle; when it equals DWELL_CYC-1, go to NEXT.
REQ-018 Auto-scan next channel SHALL be (Test+1) mod 8, so 7 wraps to 0.
REQ-019 Request-mode next channel SHALL be the first set req bit searched circularly starting at (last granted + 1).
REQ-020 If the only requester is the current channel, request mode SHALL re-grant the same channel and SHALL NOT pulse ch_chg.
REQ-021 Request mode, HOLD: if req[Test] drops, go to NEXT on the following cycle (early release).
- If req==0 at that NEXT, go to IDLE with grant=0 and Test unchanged.
REQ-022 Any change of mode SHALL force IDLE on the next cycle.
- The counter is cleared on that forced transition.
- Test holds its value except in manual mode.
REQ-023 The dwell counter SHALL be 32 bits wide and SHALL never wrap, because the terminal compare resets it.
REQ-024 A rising cpu_wr coinciding with NEXT SHALL still produce EN on the next cycle; scheduling and EN are independent.

Reset
REQ-025 While rst is low: Test=0, EN=0, grant=0, ch_chg=0, FSM=IDLE, counter=0, round-robin pointer=7 (channel 0 searched first).
REQ-026 Assertion of rst mid-HOLD SHALL abort immediately (asynchronous); release SHALL resume from IDLE at the next clk edge.

Structure
REQ-027 A shared package SHALL hold the mode encodings, the FSM state encodings and the channel count (8).
REQ-028 Circular first-one search SHALL be one sub-module, rr_pick8, with inputs req[7:0] and ptr[2:0] and outputs valid and idx[2:0].
- rr_pick8 SHALL be purely combinational.
REQ-029 All outputs SHALL be registered.

Verification
REQ-030 Reset, then mode=01 with DWELL_CYC=4.
- Required: Test sequence 1,2,3,...,7,0, each value held 4 cycles, with ch_chg at every step.
REQ-031 mode=10, req=8'b1010_0100, DWELL_CYC=4.
- Required: grants 2,5,7,2,... in that order.
REQ-032 mode=10, hold on channel 5, then clear req[5] at cycle 2 of HOLD with req=8'b0000_0001.
- Required: NEXT on the following cycle, then Test=0.
REQ-033 mode=00, sw_sel changes 3 -> 6.
- Required: Test=6 one cycle later, grant=8'h40, ch_chg=1 for one cycle.
REQ-034 Single-cycle cpu_wr pulses at arbitrary times, including during NEXT.
- Required: each pulse gives exactly one EN, one cycle later.
REQ-035 rst driven low mid-HOLD on channel 4, asynchronous to clk.
- Required: Test=0 and grant=0 immediately.
- Required: after release, the first auto-scan grant is channel 1.
